// File: rtl/serial_mac_writeback_if.sv
// Loader-to-MAC bus: enable, weight/feature pair stream, output base and the
// memory write-back / result signals.
interface serial_mac_writeback_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);
  logic              en;
  logic              acc_en;
  logic [DATA_W-1:0] w_in;
  logic [DATA_W-1:0] f_in;
  logic [7:0]        out_baseaddr;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              we;
  logic [5:0]        addr;
  logic [DATA_W-1:0] d;
  logic              is_done_o;

  modport master (
    output en, acc_en, w_in, f_in, out_baseaddr,
    input  result, result_valid, we, addr, d, is_done_o
  );

  modport slave (
    input  en, acc_en, w_in, f_in, out_baseaddr,
    output result, result_valid, we, addr, d, is_done_o
  );
endinterface

// File: rtl/serial_mac_writeback.sv
// Serial MAC: accumulates NUM_TAPS weight*feature products per window and
// writes the saturated byte back to a 64-entry memory at base+out_cnt.
module serial_mac_writeback #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter int NUM_TAPS = 9
) (
  input logic                   clk,
  input logic                   rst,
  serial_mac_writeback_if.slave bus
);
  localparam int TAP_W = $clog2(NUM_TAPS + 1);
  localparam logic [ACC_W-1:0] D_MAX = ACC_W'((1 << DATA_W) - 1);

  typedef enum logic [1:0] {IDLE, ACC, WRITE} state_t;

  state_t            state, state_n;
  logic [ACC_W-1:0]  acc, acc_n;
  logic [TAP_W-1:0]  tap_cnt, tap_n;
  logic [5:0]        out_cnt, out_cnt_n;
  logic [ACC_W-1:0]  result, result_n;
  logic [5:0]        addr, addr_n;
  logic [DATA_W-1:0] d, d_n;

  logic [2*DATA_W-1:0] prod_raw;
  logic [ACC_W-1:0]    product;
  logic [ACC_W-1:0]    sum;
  logic                last_tap;
  logic                unused_base_hi;

  assign prod_raw       = bus.w_in * bus.f_in;
  assign product        = ACC_W'(prod_raw);
  assign sum            = acc + product;
  assign last_tap       = (tap_cnt == TAP_W'(NUM_TAPS - 1));
  assign unused_base_hi = ^bus.out_baseaddr[7:6];

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    tap_n     = tap_cnt;
    out_cnt_n = out_cnt;
    result_n  = result;
    addr_n    = '0;
    d_n       = '0;
    case (state)
      IDLE: begin
        if (bus.en) begin
          state_n = ACC;
          acc_n   = '0;
          tap_n   = '0;
        end
      end
      ACC: begin
        if (!bus.en) begin
          state_n = IDLE;
          acc_n   = '0;
          tap_n   = '0;
        end else if (bus.acc_en) begin
          acc_n = sum;
          tap_n = tap_cnt + 1'b1;
          // Write-back outputs are registered on entry to WRITE so they
          // carry no combinational path from the inputs.
          if (last_tap) begin
            state_n  = WRITE;
            result_n = sum;
            addr_n   = bus.out_baseaddr[5:0] + out_cnt;
            d_n      = (sum > D_MAX) ? '1 : sum[DATA_W-1:0];
          end
        end
      end
      WRITE: begin
        out_cnt_n = out_cnt + 1'b1;
        if (bus.en) begin
          state_n = ACC;
          if (bus.acc_en) begin
            acc_n = product;
            tap_n = TAP_W'(1);
          end else begin
            acc_n = '0;
            tap_n = '0;
          end
        end else begin
          state_n = IDLE;
          acc_n   = '0;
          tap_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        acc_n   = '0;
        tap_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      acc     <= '0;
      tap_cnt <= '0;
      out_cnt <= '0;
      result  <= '0;
      addr    <= '0;
      d       <= '0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      tap_cnt <= tap_n;
      out_cnt <= out_cnt_n;
      result  <= result_n;
      addr    <= addr_n;
      d       <= d_n;
    end
  end

  assign bus.result       = result;
  assign bus.result_valid = (state == WRITE);
  assign bus.we           = (state == WRITE);
  assign bus.is_done_o    = (state == WRITE);
  assign bus.addr         = addr;
  assign bus.d            = d;
endmodule

// File: tb/tb_serial_mac_writeback.sv
// Self-checking bench for serial_mac_writeback: every pair accepted while en
// stays high feeds a window model; writes are collected and compared.
module tb_serial_mac_writeback;
  localparam int DATA_W   = 8;
  localparam int ACC_W    = 20;
  localparam int NUM_TAPS = 9;

  typedef struct {
    logic [5:0]       addr;
    logic [7:0]       d;
    logic [ACC_W-1:0] result;
    logic             rv;
    logic             done;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_mac_writeback_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  serial_mac_writeback #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .NUM_TAPS(NUM_TAPS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int passed = 0;
  int total  = 0;
  int unsigned ptr = 0;
  wr_t wq[$];

  // Each captured entry is one cycle with we high.
  always @(posedge clk) begin
    #1;
    if (bus.we === 1'b1)
      wq.push_back('{bus.addr, bus.d, bus.result, bus.result_valid, bus.is_done_o});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pair(input logic [7:0] w, input logic [7:0] f);
    bus.acc_en = 1'b1;
    bus.w_in   = w;
    bus.f_in   = f;
    @(negedge clk);
    bus.acc_en = 1'b0;
    bus.w_in   = 8'($urandom);
    bus.f_in   = 8'($urandom);
  endtask

  task automatic start(input logic [7:0] base);
    bus.out_baseaddr = base;
    bus.en = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 100 && wq.size() < n; i++) @(negedge clk);
    cyc(3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    ptr = 0;
    wq.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if ({bus.result, bus.result_valid, bus.we, bus.addr, bus.d, bus.is_done_o} !== '0)
      $display("FAIL reset_outputs: got result=%0d rv=%b we=%b addr=%0h d=%0h done=%b, want all 0",
               bus.result, bus.result_valid, bus.we, bus.addr, bus.d, bus.is_done_o);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    wr_t w;
    start(8'h20);
    for (int i = 0; i < NUM_TAPS; i++) begin pair(8'd2, 8'd3); cyc(1); end
    wait_writes(1);
    total++;
    if (wq.size() !== 1) $display("FAIL basic_count: got %0d writes, want 1", wq.size());
    else passed++;
    if (wq.size() > 0) begin
      w = wq.pop_front();
      total++;
      if ({w.addr, w.d, w.result, w.rv, w.done} !== {6'h20, 8'd54, 20'd54, 1'b1, 1'b1})
        $display("FAIL basic_write: got addr=%0h d=%0d result=%0d rv=%b done=%b, want 20/54/54/1/1",
                 w.addr, w.d, w.result, w.rv, w.done);
      else passed++;
    end
    ptr = ptr + 1;
    total++;
    if ({bus.result, bus.we, bus.result_valid, bus.is_done_o, bus.d} !== {20'd54, 3'b000, 8'd0})
      $display("FAIL basic_hold: got result=%0d we=%b rv=%b done=%b d=%0d, want 54/0/0/0/0",
               bus.result, bus.we, bus.result_valid, bus.is_done_o, bus.d);
    else passed++;
    wq.delete();
  endtask

  // Stream of windows with en held high; pairs may hit the WRITE cycle.
  task automatic run_windows(input string name, input logic [7:0] base, input int nwin,
                             input int wsel, input int maxgap);
    int unsigned sums[$];
    logic [7:0] w, f;
    int unsigned s;
    wr_t got;
    bus.out_baseaddr = base;
    for (int k = 0; k < nwin; k++) begin
      s = 0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        case (wsel)
          0: begin w = 8'($urandom); f = 8'($urandom); end
          1: begin w = 8'd255; f = 8'd255; end
          2: begin w = 8'd1; f = 8'd28; end
          3: begin w = 8'd1; f = 8'd1; end
          default: begin w = 8'd1; f = 8'd2; end
        endcase
        s += int'(w) * int'(f);
        pair(w, f);
        if (maxgap > 0) cyc(int'($urandom_range(maxgap, 0)));
      end
      sums.push_back(s);
    end
    wait_writes(nwin);
    total++;
    if (wq.size() !== nwin) $display("FAIL %s_count: got %0d writes, want %0d", name, wq.size(), nwin);
    else passed++;
    for (int k = 0; k < nwin && wq.size() > 0; k++) begin
      logic [5:0] ea;
      logic [7:0] ed;
      got = wq.pop_front();
      ea = 6'((int'(base[5:0]) + ptr) % 64);
      ed = (sums[k] > 255) ? 8'd255 : 8'(sums[k]);
      total++;
      if ({got.addr, got.d, got.result, got.rv, got.done} !== {ea, ed, 20'(sums[k]), 1'b1, 1'b1})
        $display("FAIL %s_win%0d: got addr=%0h d=%0d result=%0d rv=%b done=%b, want addr=%0h d=%0d result=%0d rv=1 done=1",
                 name, k, got.addr, got.d, got.result, got.rv, got.done, ea, ed, sums[k]);
      else passed++;
      ptr = (ptr + 1) % 64;
    end
    wq.delete();
  endtask

  task automatic test_saturation();
    run_windows("sat255", 8'h20, 1, 1, 0);
    run_windows("sat28", 8'h20, 1, 2, 1);
  endtask

  task automatic test_random();
    run_windows("random", 8'($urandom), 4, 0, 2);
  endtask

  task automatic test_back_to_back();
    run_windows("b2b", 8'h10, 2, 3, 0);
  endtask

  task automatic test_wrap();
    wr_t w;
    do_reset();
    start(8'h3F);
    for (int i = 0; i < NUM_TAPS; i++) pair(8'd1, 8'd1);
    bus.out_baseaddr = 8'hFF;
    for (int i = 0; i < NUM_TAPS; i++) pair(8'd1, 8'd2);
    wait_writes(2);
    total++;
    if (wq.size() !== 2) $display("FAIL wrap_count: got %0d writes, want 2", wq.size());
    else passed++;
    if (wq.size() == 2) begin
      w = wq.pop_front();
      total++;
      if (w.addr !== 6'h3F) $display("FAIL wrap_addr0: got %0h, want 3f", w.addr);
      else passed++;
      w = wq.pop_front();
      total++;
      if ({w.addr, w.d} !== {6'h00, 8'd18}) $display("FAIL wrap_addr1: got addr=%0h d=%0d, want 0/18", w.addr, w.d);
      else passed++;
    end
    ptr = 2;
    wq.delete();
  endtask

  task automatic test_abort();
    logic [ACC_W-1:0] held;
    held = bus.result;
    start(8'h05);
    for (int i = 0; i < 5; i++) pair(8'($urandom), 8'($urandom));
    bus.en = 1'b0;
    cyc(4);
    total++;
    if ({wq.size(), bus.result} !== {32'd0, held})
      $display("FAIL abort_nowrite: got %0d writes result=%0d, want 0 writes result=%0d", wq.size(), bus.result, held);
    else passed++;
    start(8'h05);
    run_windows("abort", 8'h05, 1, 4, 1);
  endtask

  task automatic test_async_reset();
    start(8'h08);
    for (int i = 0; i < 4; i++) pair(8'($urandom), 8'($urandom));
    #2 rst = 1'b0;
    #1;
    total++;
    if ({bus.result, bus.result_valid, bus.we, bus.addr, bus.d, bus.is_done_o} !== '0)
      $display("FAIL async_reset: got result=%0d rv=%b we=%b addr=%0h d=%0h done=%b, want all 0",
               bus.result, bus.result_valid, bus.we, bus.addr, bus.d, bus.is_done_o);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    ptr = 0;
    wq.delete();
    bus.en = 1'b0;
    @(negedge clk);
    start(8'h08);
    run_windows("post_reset", 8'h08, 1, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b0;
    bus.acc_en = 1'b0;
    bus.w_in = '0;
    bus.f_in = '0;
    bus.out_baseaddr = '0;
    cyc(2);
    test_reset();
    test_basic();
    test_saturation();
    test_random();
    test_back_to_back();
    test_wrap();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_mac_writeback.md
Name: serial_mac_writeback

Overview:
- Serial-mode stage directly downstream of the serial data loader.
- Consumes the loader's registered weight/feature byte pairs, qualified by its acc_en strobe.
- Accumulates NUM_TAPS unsigned products (one 3x3 window). Writes the saturated 8-bit result back to the shared 64-entry memory, then re-arms for the next window.

Parameters:
- DATA_W, 8, width of weight, feature and write-back data.
- ACC_W, 20, accumulator width. Holds 9 x 255 x 255 = 585225 without overflow.
- NUM_TAPS, 9, products per output window.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  stage enable. Low aborts and idles the block.
- acc_en  input  1  one-cycle strobe: w_in/f_in carry a valid pair this cycle.
- w_in  input  DATA_W  weight byte from the loader.
- f_in  input  DATA_W  feature byte from the loader.
- out_baseaddr  input  8  base address of the output region; only [5:0] is used.
- result  output  ACC_W  full-precision window sum, held until the next window completes.
- result_valid  output  1  one-cycle pulse when result updates.
- we  output  1  memory write enable.
- addr  output  6  memory write address.
- d  output  DATA_W  memory write data.
- is_done_o  output  1  one-cycle pulse, coincident with we.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; acc, tap_cnt, out_cnt, result=0; result_valid, we, is_done_o=0; addr, d=0.
- Product: unsigned w_in*f_in, zero-extended to ACC_W, combinational into the accumulator adder. No multiplier pipeline.
- State machine (IDLE, ACC, WRITE):
  - IDLE:
    - acc_en ignored.
    - en=1 -> ACC with acc=0, tap_cnt=0.
  - ACC:
    - On acc_en=1: acc <= acc+product; tap_cnt <= tap_cnt+1.
    - When the accepted pair is tap NUM_TAPS: result <= acc+product, state -> WRITE. Result latency = 1 cycle after the last acc_en edge.
    - en=0 in ACC (takes priority over acc_en): -> IDLE, acc/tap_cnt cleared, no write, out_cnt kept.
  - WRITE (exactly one cycle):
    - we=1, result_valid=1, is_done_o=1.
    - addr = out_baseaddr[5:0] + out_cnt, modulo 64.
    - d = 255 if result > 255, else result[7:0] (saturating).
    - out_cnt increments at the end of WRITE, wrapping 63 -> 0.
    - Next state: ACC if en=1, else IDLE.
- acc_en during WRITE with en=1: accepted as tap 1 of the next window (acc <= product, tap_cnt <= 1). No pair is dropped.
- acc_en during WRITE with en=0: ignored. The write still completes, then -> IDLE.
- Outputs we/addr/d/result_valid/is_done_o are driven from registered state; no combinational path from inputs.
- Outside WRITE, we/result_valid/is_done_o=0 and d=0.
- result is never cleared except by reset.
- out_cnt resets only via rst. en toggling does not reset the output pointer.
- tap_cnt never exceeds NUM_TAPS.

Test Plan:
- Basic window:
  - Stimulus: reset, en=1, 9 acc_en pulses every 2nd cycle with w=2, f=3, out_baseaddr=0x20.
  - Response: one cycle after the 9th pulse, result=54, d=54, we=1, addr=0x20, is_done_o=1 for exactly one cycle.
- Saturation and full precision:
  - Stimulus: 9 pairs w=255, f=255.
  - Response: result=585225, d=255.
  - Stimulus: 9 pairs w=1, f=28.
  - Response: result=252, d=252.
- Back-to-back windows:
  - Stimulus: acc_en on every cycle, including the WRITE cycle, for 18 pairs of w=1, f=1.
  - Response: two writes, both result=9, at addr base+0 and base+1. No pair lost.
- Pointer wrap:
  - Stimulus: out_baseaddr=0x3F, run 2 windows.
  - Response: addr=0x3F then 0x00. Upper base bits are ignored (0xFF behaves like 0x3F).
- Abort:
  - Stimulus: drop en after 5 pairs, then re-enable and run a full window of w=1, f=2.
  - Response: no write during the abort. The next write has result=18 at the unchanged pointer.
- Asynchronous reset mid-window:
  - Stimulus: assert rst low between clock edges after 4 pairs.
  - Response: all outputs 0 immediately, without waiting for a clock edge. After release the next window writes at addr=base+0 with a fresh sum.
